// File: rtl/dec_is_queue.sv
// Decode-to-issue transmit queue: in-order FIFO with a valid/stall handshake.
// It holds decode after an exception-tagged push, and flush or reset empties it.
module dec_is_queue #(
   parameter int ADDR  = 32,
   parameter int DATA  = 32,
   parameter int OP_W  = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset_,
   input  logic                       flush,
   input  logic                       dec_valid,
   input  logic [ADDR-1:0]            dec_pc,
   input  logic [DATA-1:0]            dec_imm,
   input  logic [OP_W-1:0]            dec_op,
   input  logic                       dec_exp,
   output logic                       dec_stall,
   output logic                       is_valid,
   output logic [ADDR-1:0]            is_pc,
   output logic [DATA-1:0]            is_imm,
   output logic [OP_W-1:0]            is_op,
   output logic                       is_exp,
   input  logic                       is_stall,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   typedef enum logic {RUN, HOLD} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   head_q, tail_q;
   logic [CW-1:0]   count_q;
   logic            push, pop;
   logic            clear;

   logic [ADDR-1:0] pc_mem  [DEPTH];
   logic [DATA-1:0] imm_mem [DEPTH];
   logic [OP_W-1:0] op_mem  [DEPTH];
   logic            exp_mem [DEPTH];

   // Handshake outputs depend only on registered state; dec_valid and
   // is_stall feed the next-state logic alone.
   always_comb begin
      clear     = ~reset_ | flush;
      is_valid  = (count_q != '0);
      dec_stall = (count_q == CNT_FULL) | (state_q == HOLD);
      push      = dec_valid & ~dec_stall;
      pop       = is_valid & ~is_stall;
      state_d   = state_q;
      if (clear) begin
         state_d = RUN;
      end else if (state_q == RUN && push && dec_exp) begin
         state_d = HOLD;
      end
   end

   always_ff @(posedge clk) begin
      state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            tail_q <= tail_q + PTR_ONE;
         end
         if (pop) begin
            head_q <= head_q + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

   // Payload storage needs no reset: stale entries are never exposed while empty.
   always_ff @(posedge clk) begin
      if (!clear && push) begin
         pc_mem[tail_q]  <= dec_pc;
         imm_mem[tail_q] <= dec_imm;
         op_mem[tail_q]  <= dec_op;
         exp_mem[tail_q] <= dec_exp;
      end
   end

   always_comb begin
      is_pc  = '0;
      is_imm = '0;
      is_op  = '0;
      is_exp = 1'b0;
      if (is_valid) begin
         is_pc  = pc_mem[head_q];
         is_imm = imm_mem[head_q];
         is_op  = op_mem[head_q];
         is_exp = exp_mem[head_q];
      end
   end

   assign count = count_q;

endmodule

// File: tb/tb_dec_is_queue.sv
// Randomized and directed bench for dec_is_queue against a queue-based reference model.
module tb_dec_is_queue;

   localparam int ADDR  = 32;
   localparam int DATA  = 32;
   localparam int OP_W  = 32;
   localparam int DEPTH = 4;

   logic            clk = 1'b0;
   logic            reset_;
   logic            flush;
   logic            dec_valid;
   logic [ADDR-1:0] dec_pc;
   logic [DATA-1:0] dec_imm;
   logic [OP_W-1:0] dec_op;
   logic            dec_exp;
   logic            dec_stall;
   logic            is_valid;
   logic [ADDR-1:0] is_pc;
   logic [DATA-1:0] is_imm;
   logic [OP_W-1:0] is_op;
   logic            is_exp;
   logic            is_stall;
   logic [$clog2(DEPTH):0] count;

   dec_is_queue #(.ADDR(ADDR), .DATA(DATA), .OP_W(OP_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset_(reset_), .flush(flush),
      .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_imm(dec_imm),
      .dec_op(dec_op), .dec_exp(dec_exp), .dec_stall(dec_stall),
      .is_valid(is_valid), .is_pc(is_pc), .is_imm(is_imm), .is_op(is_op),
      .is_exp(is_exp), .is_stall(is_stall), .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [ADDR-1:0] pc;
      logic [DATA-1:0] imm;
      logic [OP_W-1:0] op;
      logic            exp;
   } ent_t;

   ent_t mq[$];
   bit   m_hold;
   int   n_checks;
   int   n_errors;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Compare DUT outputs with the model, then advance both across one clock edge.
   task automatic step();
      bit   m_stall, m_valid, do_push, do_pop;
      ent_t e;
      m_valid = (mq.size() != 0);
      m_stall = (mq.size() == DEPTH) || m_hold;
      check("is_valid", 64'(is_valid), 64'(m_valid));
      check("dec_stall", 64'(dec_stall), 64'(m_stall));
      check("count", 64'(count), 64'(mq.size()));
      check("is_pc", 64'(is_pc), m_valid ? 64'(mq[0].pc) : 64'd0);
      check("is_imm", 64'(is_imm), m_valid ? 64'(mq[0].imm) : 64'd0);
      check("is_op", 64'(is_op), m_valid ? 64'(mq[0].op) : 64'd0);
      check("is_exp", 64'(is_exp), m_valid ? 64'(mq[0].exp) : 64'd0);
      if (!reset_ || flush) begin
         mq.delete();
         m_hold = 0;
      end else begin
         do_pop  = m_valid && !is_stall;
         do_push = dec_valid && !m_stall;
         if (do_pop) void'(mq.pop_front());
         if (do_push) begin
            e.pc = dec_pc; e.imm = dec_imm; e.op = dec_op; e.exp = dec_exp;
            mq.push_back(e);
            if (dec_exp) m_hold = 1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input logic [ADDR-1:0] pc, input bit ex);
      dec_valid = v;
      dec_pc    = pc;
      dec_imm   = pc ^ 32'h5a5a_0000;
      dec_op    = {pc[15:0], ~pc[15:0]};
      dec_exp   = ex;
   endtask

   initial begin
      reset_ = 1'b0; flush = 1'b0; is_stall = 1'b0;
      drive(0, '0, 0);
      m_hold = 0;
      n_checks = 0;
      n_errors = 0;
      @(posedge clk);
      #1;
      step();
      reset_ = 1'b1;

      // three back-to-back pushes drained with no issue stall
      for (int i = 0; i < 3; i++) begin
         drive(1, 32'h100 + 32'(4 * i), 0);
         step();
      end
      drive(0, '0, 0);
      for (int i = 0; i < 4; i++) step();
      check("drain_count", 64'(count), 64'd0);

      // fill under issue stall, fifth push refused, drain across wrap
      is_stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(1, 32'h300 + 32'(4 * i), 0);
         step();
      end
      check("full_stall", 64'(dec_stall), 64'd1);
      drive(0, '0, 0);
      is_stall = 1'b0;
      step();
      check("stall_fall", 64'(dec_stall), 64'd0);
      for (int i = 0; i < 4; i++) step();

      // full with concurrent push and pop: push rejected
      is_stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1, 32'h400 + 32'(4 * i), 0);
         step();
      end
      drive(1, 32'h4f0, 0);
      is_stall = 1'b0;
      step();
      check("full_pop_count", 64'(count), 64'd3);
      drive(0, '0, 0);
      for (int i = 0; i < 4; i++) step();

      // exception push enters HOLD, drains, flush releases
      drive(1, 32'h200, 1);
      step();
      for (int i = 0; i < 3; i++) begin
         drive(1, 32'h204 + 32'(4 * i), 0);
         step();
         check("hold_stall", 64'(dec_stall), 64'd1);
      end
      drive(0, '0, 0);
      step();
      check("hold_empty", 64'(count), 64'd0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_unstall", 64'(dec_stall), 64'd0);

      // flush with a concurrent push
      is_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1, 32'h500 + 32'(4 * i), 0);
         step();
      end
      flush = 1'b1;
      drive(1, 32'h50c, 0);
      step();
      flush = 1'b0;
      drive(0, '0, 0);
      check("flush_count", 64'(count), 64'd0);
      check("flush_pc", 64'(is_pc), 64'd0);
      step();

      // reset mid-stream with HOLD active
      drive(1, 32'h600, 0);
      step();
      drive(1, 32'h604, 1);
      step();
      drive(0, '0, 0);
      check("pre_reset_stall", 64'(dec_stall), 64'd1);
      reset_ = 1'b0;
      step();
      reset_ = 1'b1;
      check("reset_count", 64'(count), 64'd0);
      check("reset_stall", 64'(dec_stall), 64'd0);
      step();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 3) != 0), $urandom(), ($urandom_range(0, 15) == 0));
         is_stall = ($urandom_range(0, 2) == 0);
         flush    = ($urandom_range(0, 40) == 0);
         reset_   = ($urandom_range(0, 200) != 0);
         step();
      end
      reset_ = 1'b1; flush = 1'b0; drive(0, '0, 0); is_stall = 1'b0;
      for (int i = 0; i < 6; i++) step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dec_is_queue.md
# dec_is_queue

Decode-side transmitter for the decode→issue channel. Buffers decoded instructions in a small in-order FIFO and presents them to the issue stage with a valid/stall handshake. Stalls decode when full and after an exception-tagged instruction, and empties on pipeline flush. Sits between the decoder output and the issue queue's decode-facing input.

## Interface
- ADDR, default `AddrWidth` (32): PC width.
- DATA, default `DataWidth` (32): immediate width.
- OP_W, default 32: width of the opaque decoded-operation bundle (unit, opcode, register indices).
- DEPTH, default 4: number of entries; power of two, ≥2.
- clk  in  1  clock; all state updates on rising edge.
- reset_  in  1  synchronous, active-low reset.
- flush  in  1  pipeline flush (mispredict/exception redirect).
- dec_valid  in  1  decoder presents an instruction.
- dec_pc  in  ADDR  instruction PC.
- dec_imm  in  DATA  decoded immediate.
- dec_op  in  OP_W  decoded operation bundle.
- dec_exp  in  1  instruction carries a decode/fetch exception.
- dec_stall  out  1  queue cannot accept this cycle.
- is_valid  out  1  head entry valid toward issue.
- is_pc  out  ADDR  head PC.
- is_imm  out  DATA  head immediate.
- is_op  out  OP_W  head operation bundle.
- is_exp  out  1  head exception flag.
- is_stall  in  1  issue cannot accept this cycle.
- count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Storage: DEPTH entries {pc, imm, op, exp}. Head/tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is kept in a counter.
- Push = dec_valid & ~dec_stall: write at tail, advance tail.
- Pop = is_valid & ~is_stall: advance head.
- Simultaneous push and pop: count unchanged, both pointers advance.
- is_valid = (count != 0). The is_* payload is driven from the head entry and forced to 0 when empty.
- dec_stall = (count == DEPTH) | (state == HOLD).
  - No full-bypass: when full, dec_stall stays 1 even if a pop occurs in the same cycle.
- FSM states RUN and HOLD.
  - RUN→HOLD on a push with dec_exp=1. That entry itself is enqueued.
  - HOLD→RUN only on flush.
  - HOLD does not block pops; the queue drains normally.
- flush has highest priority. Next cycle:
  - count=0 and head=tail=0;
  - state=RUN;
  - a same-cycle push is discarded and a same-cycle pop has no effect.
- Reset (reset_=0 at edge) behaves as flush. Reset values:
  - is_valid=0 and all is_* =0;
  - count=0;
  - dec_stall=0;
  - state=RUN.
- Reset asserted mid-stream discards all entries; no partial state survives.

## Timing
- Enqueue→visible: an instruction pushed at edge N appears on is_* after edge N (cycle N+1). No same-cycle bypass from dec_* to is_*.
- Pop at edge N exposes the next entry in cycle N+1.
- Throughput: 1 instruction/cycle when not full and issue not stalling.
- dec_stall and is_valid are functions of registered state only. There is no combinational path from dec_valid or is_stall to any output.
- dec_stall rises in the cycle after the push that fills the queue or enters HOLD.
- dec_stall falls in the cycle after the first pop from full (RUN), or after flush.

## Test plan
- Reset, then push 3 entries with pc 0x100/0x104/0x108 and is_stall=0.
  - is_valid rises 1 cycle after the first push.
  - Outputs are 0x100, 0x104, 0x108 in consecutive cycles.
  - count returns to 0.
- Hold is_stall=1 and push 5 with DEPTH=4.
  - dec_stall=1 after the 4th push and the 5th entry is not accepted.
  - Release is_stall: dec_stall falls 1 cycle after the first pop.
  - FIFO order is preserved across the pointer wrap.
- Full queue with dec_valid=1 and is_stall=0 in the same cycle: pop occurs, push is rejected, count goes 4→3.
- Push pc 0x200 with dec_exp=1, then dec_valid=1 for 3 cycles.
  - Only 0x200 is enqueued and dec_stall stays 1.
  - 0x200 drains with is_exp=1.
  - flush returns dec_stall to 0.
- With 3 entries queued, assert flush together with dec_valid=1.
  - Next cycle: count=0, is_valid=0, is_pc=0.
  - The pushed entry is absent.
- Assert reset_=0 with 2 entries queued and HOLD active: all outputs return to reset values next cycle and state is RUN.
